sp_mac_lane_pe: RTL

SP_MAC_LANE_PE -- requirements
Module: sp_mac_lane_pe

---
 rtl/sp_mac_lane_pe.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sp_mac_lane_pe.sv
// Sparse-row MAC processing element: accepts up to LANES CSR nonzeros per beat, multiplies them
// by weights fetched from an external memory and accumulates one signed dot-product per row.
module sp_mac_lane_pe #(
  parameter int DATA_WIDTH    = 8,
  parameter int COL_IDX_WIDTH = 5,
  parameter int LANES         = 2,
  parameter int ACC_WIDTH     = 32,
  parameter int SAT_EN        = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0]                 in_mask,
  input  logic [LANES*COL_IDX_WIDTH-1:0]   in_col_idx,
  input  logic [LANES*DATA_WIDTH-1:0]      in_value,
  input  logic                             in_last,
  output logic [LANES*COL_IDX_WIDTH-1:0]   weight_addr,
  output logic                             weight_en,
  input  logic [LANES*DATA_WIDTH-1:0]      weight_dout,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic signed [ACC_WIDTH-1:0]      res_data,
  output logic                             res_sat,
  output logic [15:0]                      rows_done
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int PSUM_W = PROD_W + $clog2(LANES) + 1;
  localparam int WIDE_W = (PSUM_W > ACC_WIDTH) ? PSUM_W + 1 : ACC_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [WIDE_W-1:0] ACC_MAX_W =
    {{(WIDE_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] ACC_MIN_W =
    {{(WIDE_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    ROW  = 1'b1
  } acc_state_t;

  // Whole pipeline moves only when the result slot can take a new row
  logic advance;

  // Stage P inputs (beat accepted on the previous edge)
  logic                          p_valid;
  logic [LANES-1:0]              p_mask;
  logic [LANES*DATA_WIDTH-1:0]   p_value;
  logic                          p_last;

  // Stage P combinational products
  logic signed [PROD_W-1:0]      lane_v;
  logic signed [PROD_W-1:0]      lane_w;
  logic signed [PROD_W-1:0]      prod;
  logic signed [PSUM_W-1:0]      psum;

  // Stage A inputs
  logic                          a_valid;
  logic signed [PSUM_W-1:0]      a_psum;
  logic                          a_any;
  logic                          a_last;

  // Accumulator
  acc_state_t                    state, state_next;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic                          sticky;
  logic signed [WIDE_W-1:0]      addend_w;
  logic signed [WIDE_W-1:0]      acc_w;
  logic signed [WIDE_W-1:0]      sum_w;
  logic                          ovf;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic                          sticky_next;
  logic                          a_fire;

  assign advance     = !res_valid || res_ready;
  assign in_ready    = advance;
  assign weight_addr = in_col_idx;
  assign weight_en   = in_valid && advance && rst_n;
  assign a_fire      = advance && a_valid;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_mask  <= '0;
      p_value <= '0;
      p_last  <= 1'b0;
    end else if (advance) begin
      p_valid <= in_valid;
      p_mask  <= in_mask;
      p_value <= in_value;
      p_last  <= in_last;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    psum   = '0;
    lane_v = '0;
    lane_w = '0;
    prod   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_v = {{DATA_WIDTH{p_value[i*DATA_WIDTH+DATA_WIDTH-1]}},
                p_value[i*DATA_WIDTH +: DATA_WIDTH]};
      lane_w = {{DATA_WIDTH{weight_dout[i*DATA_WIDTH+DATA_WIDTH-1]}},
                weight_dout[i*DATA_WIDTH +: DATA_WIDTH]};
      prod   = '0;
      if (p_mask[i]) prod = lane_v * lane_w;
      psum = psum + {{(PSUM_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_psum  <= '0;
      a_any   <= 1'b0;
      a_last  <= 1'b0;
    end else if (advance) begin
      a_valid <= p_valid;
      a_psum  <= psum;
      a_any   <= |p_mask;
      a_last  <= p_last;
    end
  end

  // Sum is formed wide enough that clamp/overflow decisions see the true value
  always_comb begin
    addend_w = '0;
    if (a_any) addend_w = {{(WIDE_W-PSUM_W){a_psum[PSUM_W-1]}}, a_psum};
    acc_w    = {{(WIDE_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    sum_w    = (state == IDLE) ? addend_w : acc_w + addend_w;
    ovf      = (sum_w > ACC_MAX_W) || (sum_w < ACC_MIN_W);
    acc_next = sum_w[ACC_WIDTH-1:0];
    if ((SAT_EN != 0) && ovf) acc_next = sum_w[WIDE_W-1] ? ACC_MIN : ACC_MAX;
    sticky_next = ovf || ((state == ROW) && sticky);
  end

  always_comb begin
    state_next = state;
    if (a_fire) state_next = a_last ? IDLE : ROW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (a_fire) begin
      acc    <= a_last ? '0 : acc_next;
      sticky <= a_last ? 1'b0 : sticky_next;
    end
  end

  // A finishing row may load on the same edge the previous result is handed off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
    end else if (a_fire && a_last) begin
      res_valid <= 1'b1;
      res_data  <= acc_next;
      res_sat   <= sticky_next;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      rows_done <= '0;
    else if (res_valid && res_ready) rows_done <= rows_done + 16'd1;
  end

endmodule
